fb_console_writer: RTL and testbench
====================================

Name: fb_console_writer

Overview:
Character-stream producer for the VGA text framebuffer. It drives the framebuffer's write port (fb_data/fb_addr/fb_we), which the VGA controller reads. It accepts bytes over a valid/ready handshake, tracks a cursor, and interprets a small set of control codes. On every row advance it blanks the new row, because the framebuffer write port cannot be read back for scrolling.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen; COLS*ROWS must be <= 2**ADDR_W
ADDR_W, 12, framebuffer address width
BLANK, 8'h20, fill byte used by clear operations and backspace

Ports:
clk  input  1  single clock, all logic is posedge clk
rst  input  1  asynchronous, active-high reset
char_in  input  8  byte to display
char_valid  input  1  char_in is valid
char_ready  output  1  block can accept a byte this cycle
fb_data  output  8  framebuffer write data (registered)
fb_addr  output  ADDR_W  framebuffer write address (registered)
fb_we  output  1  framebuffer write strobe, one cycle per cell (registered)
cursor_col  output  7  current column, 0..COLS-1
cursor_row  output  5  current row, 0..ROWS-1
busy  output  1  clear operation in progress (equals !char_ready)

Behaviour:
- Reset: state IDLE; fb_we=0, fb_addr=0, fb_data=0; cursor_col=0, cursor_row=0; row_base=0; char_ready=1 once rst is released. Framebuffer contents are not touched by reset.
- Address formation: addr = row_base + col. row_base is kept incrementally: +COLS on row advance, 0 on wrap. No multiplier is used.
- Handshake: char_ready = (state==IDLE), combinational from state. A byte is accepted on a posedge where char_valid && char_ready. char_in is sampled only on acceptance.
- States: IDLE, CLR_LINE, CLR_ALL.
- IDLE, printable byte (0x20..0x7E):
  - Next cycle: fb_we=1, fb_addr=row_base+col, fb_data=byte.
  - col+1. If col was COLS-1: col=0 and row advance.
  - Back-to-back printable bytes are accepted every cycle when no row advance occurs.
- IDLE, 0x0A (LF): col=0, row advance. No character write.
- IDLE, 0x0D (CR): col=0. No write.
- IDLE, 0x08 (BS):
  - col>0: col-1, then next cycle write BLANK at the new position.
  - col==0: no-op, no write, no row change.
- IDLE, 0x0C (FF): col=0, row=0, row_base=0, enter CLR_ALL.
- IDLE, any other byte: consumed and ignored; no fb_we, cursor unchanged.
- Row advance:
  - row==ROWS-1: row=0, row_base=0.
  - Otherwise: row+1, row_base+COLS.
  - In both cases enter CLR_LINE for the new row.
- CLR_LINE: COLS consecutive cycles of fb_we=1, data BLANK, addresses row_base .. row_base+COLS-1 ascending. Return to IDLE after the last write; char_ready rises the cycle after the last fb_we.
- CLR_ALL: COLS*ROWS consecutive writes of BLANK at addresses 0..COLS*ROWS-1, then IDLE.
- Wrap triggered by a printable byte: the character write at (old row, COLS-1) is emitted first, then the CLR_LINE writes follow in the immediately following cycles with no gap.
- fb_we is 0 in every cycle not listed above. Address never exceeds COLS*ROWS-1.
- Reset mid-clear: writes stop immediately (fb_we=0 asynchronously), state returns to IDLE, and the clear is not resumed.
- char_valid held high while busy: the byte is held off and accepted on the first IDLE cycle, with no loss and no duplication.

Test Plan:
- Release reset, send 0x41 -> one fb_we pulse, addr 0, data 0x41; cursor_col=1, row=0; char_ready stays 1.
- 80 bytes 0x30 back-to-back from (0,0) -> 80 writes at addr 0..79 on consecutive cycles, then 80 writes of 0x20 at addr 80..159 with char_ready=0. After that: cursor (0,1), char_ready=1.
- Cursor at row 29, send 0x0A -> no char write; 80 writes of 0x20 at addr 0..79; cursor (0,0).
- Send 0x0C -> 2400 writes of 0x20 at addr 0..2399 in order; busy high throughout; cursor (0,0). Assert rst at write #1000 -> fb_we drops immediately, nothing further is written, char_ready=1 after release.
- At col 0 send 0x08 -> no write. At col 5 row 2 send 0x08 -> write 0x20 at addr 164; cursor_col=4.
- Send 0x07 and 0x0D at col 10 -> no fb_we for either; after 0x0D cursor_col=0, row unchanged.

Source files
------------

// File: rtl/fb_console_writer.sv
// Character-stream writer for the VGA text framebuffer: accepts bytes over valid/ready,
// tracks a cursor, handles LF/CR/BS/FF, and blanks each newly entered row.
module fb_console_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [7:0]        fb_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_ALL  = 2'd2;

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [6:0]        COL_LAST     = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST     = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(COLS);
    localparam logic [ADDR_W:0]   ROW_SPAN     = CW'(COLS);
    localparam logic [ADDR_W:0]   SCREEN_CELLS = CW'(COLS * ROWS);

    logic [1:0]        state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;

    logic              printable;
    logic              advance;
    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W:0]   clr_end;

    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign cell_addr = row_base_q + ADDR_W'(col_q);
    // Pointer is one bit wider so the end marker cannot alias to 0 when the screen fills the address space.
    assign clr_end   = (state_q == ST_CLR_ALL) ? SCREEN_CELLS : ({1'b0, row_base_q} + ROW_SPAN);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        clr_ptr_d  = clr_ptr_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    if (printable) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = cell_addr;
                        fb_data_d = char_in;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            advance = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            8'h0A: begin
                                col_d   = '0;
                                advance = 1'b1;
                            end
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d     = col_q - 7'd1;
                                    fb_we_d   = 1'b1;
                                    fb_addr_d = cell_addr - ADDR_W'(1);
                                    fb_data_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_d      = '0;
                                row_d      = '0;
                                row_base_d = '0;
                                clr_ptr_d  = '0;
                                state_d    = ST_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // One extra cycle at clr_end keeps char_ready low until after the last write is visible.
            ST_CLR_LINE, ST_CLR_ALL: begin
                if (clr_ptr_q == clr_end) begin
                    state_d = ST_IDLE;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = clr_ptr_q[ADDR_W-1:0];
                    fb_data_d = BLANK;
                    clr_ptr_d = clr_ptr_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (row_q == ROW_LAST) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + 5'd1;
                row_base_d = row_base_q + ROW_STEP;
            end
            clr_ptr_d = {1'b0, row_base_d};
            state_d   = ST_CLR_LINE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            clr_ptr_q  <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            clr_ptr_q  <= clr_ptr_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign char_ready = (state_q == ST_IDLE);
    assign busy       = ~char_ready;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_fb_console_writer.sv
// Scoreboard bench for fb_console_writer: a cursor-level model predicts every framebuffer
// write, and a negedge monitor pops and compares each observed write.
module tb_fb_console_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam logic [7:0] BLANK = 8'h20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        char_in = '0;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic [7:0]        fb_data;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              busy;

    fb_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .fb_data(fb_data), .fb_addr(fb_addr), .fb_we(fb_we),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
        bit         clr;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;
    int m_col = 0;
    int m_row = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    // Reference model: cursor in (row, col) screen coordinates, address = row*COLS + col.
    task automatic push_row_clear();
        for (int i = 0; i < COLS; i++) expq.push_back('{m_row * COLS + i, BLANK, 1'b1});
    endtask

    task automatic new_row();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_row_clear();
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            expq.push_back('{m_row * COLS + m_col, b, 1'b0});
            if (m_col == COLS - 1) new_row();
            else m_col++;
        end else if (b == 8'h0A) begin
            new_row();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                expq.push_back('{m_row * COLS + m_col, BLANK, 1'b0});
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            for (int i = 0; i < COLS * ROWS; i++) expq.push_back('{i, BLANK, 1'b1});
        end
    endtask

    // Monitor: every fb_we cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_eq_not_ready", int'(busy), int'(!char_ready));
            if (fb_we) begin
                wr_count++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", fb_addr, fb_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("wr_addr", int'(fb_addr), e.addr);
                    check("wr_data", int'(fb_data), int'(e.data));
                    if (e.clr) check("ready_low_in_clear", int'(char_ready), 0);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        char_in = b;
        char_valid = 1'b1;
        while (!char_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!char_ready) begin
            check("send_timeout", 0, 1);
            char_valid = 1'b0;
            return;
        end
        model_accept(b);
        last_acc = cyc;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((expq.size() != 0 || !char_ready) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, expq.size(), 0);
        check({name, "_col"}, int'(cursor_col), m_col);
        check({name, "_row"}, int'(cursor_row), m_row);
        check({name, "_ready"}, int'(char_ready), 1);
    endtask

    task automatic random_byte(output logic [7:0] b);
        int r;
        r = $urandom_range(0, 99);
        if (r < 75) b = 8'($urandom_range(32, 126));
        else if (r < 83) b = 8'h0A;
        else if (r < 88) b = 8'h0D;
        else if (r < 94) b = 8'h08;
        else begin
            do b = 8'($urandom_range(0, 255));
            while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int base;
        int guard;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(char_ready), 1);

        send(8'h41);
        check("single_ready_stays", int'(char_ready), 1);
        drain("single");

        send(8'h0D);
        first_acc = 0;
        for (int i = 0; i < COLS; i++) begin
            send(8'h30);
            if (i == 0) first_acc = last_acc;
        end
        check("burst_back_to_back", last_acc - first_acc, COLS - 1);
        drain("full_row");

        while (m_row != ROWS - 1) send(8'h0A);
        drain("to_last_row");
        send(8'h0A);
        drain("lf_wrap");

        send(8'h08);
        drain("bs_col0");

        send(8'h0C);
        drain("ff_full");
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        drain("to_r2c5");
        send(8'h08);
        drain("bs_r2c5");

        send(8'h0D);
        for (int i = 0; i < 10; i++) send(8'h42);
        drain("to_col10");
        base = wr_count;
        send(8'h07);
        send(8'h0D);
        repeat (3) @(negedge clk);
        check("bel_cr_no_write", wr_count - base, 0);
        drain("bel_cr");

        for (int i = 0; i < 300; i++) begin
            random_byte(b);
            send(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            if (i % 60 == 59) drain("random");
        end
        drain("random_end");

        send(8'h0C);
        base = wr_count;
        guard = 0;
        while (wr_count - base < 1000 && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("ff_reached_1000", wr_count - base, 1000);
        rst = 1'b1;
        #1;
        check("mid_clear_we_drop", int'(fb_we), 0);
        expq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_col = 0;
        m_row = 0;
        base = wr_count;
        @(negedge clk);
        check("post_rst_ready", int'(char_ready), 1);
        repeat (20) @(negedge clk);
        check("no_resume_writes", wr_count - base, 0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
